// File: rtl/blit_pkg.sv
// Shared types for the blit memory arbiter: owner encoding and the in-flight tag.
// Tags carry the write flag so a write ack leaves cpu_rdata untouched.
package blit_pkg;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_CPU  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   wr;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_DISP, wr: 1'b0};

endpackage

// File: rtl/blit_memarb_tagpipe.sv
// Fixed-depth tag delay line; one tag in and one tag out per cycle, DEPTH cycles apart.
// No backpressure: it always shifts. Reset flushes every stage so no stale ack can appear.
module blit_memarb_tagpipe
  import blit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_IDLE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/blit_memarb.sv
// Display/CPU arbiter for a pipelined 16-bit RAM; one issue per cycle, ack at grant+2+RDLAT.
// Display requests queue one deep; the CPU holds cpu_req until its ack. Ties alternate.
module blit_memarb
  import blit_pkg::*;
#(
  parameter int RDLAT = 1,
  parameter int AW    = 18
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_ack,
  output logic [15:0]   disp_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  output logic          cpu_ack,
  output logic [15:0]   cpu_rdata,
  output logic          mem_en,
  output logic [1:0]    mem_we,
  output logic [AW-2:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  logic          disp_pend, disp_infl, cpu_infl, cpu_ack_q, last_disp;
  logic [AW-2:0] disp_addr_q, disp_word;
  logic          disp_req_ok, disp_elig, cpu_elig, gnt_disp, gnt_cpu;
  logic          ret_disp, ret_cpu;
  tag_t          tag_in, tag_out;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = disp_addr[0] ^ cpu_addr[0];

  // CPU is held off in its ack cycle and the one after, while cpu_req is still winding down.
  always_comb begin
    disp_req_ok = disp_req & ~disp_pend & ~disp_infl;
    disp_elig   = disp_pend | disp_req_ok;
    cpu_elig    = cpu_req & ~cpu_infl & ~cpu_ack & ~cpu_ack_q;
    gnt_disp    = disp_elig & (~cpu_elig | ~last_disp);
    gnt_cpu     = cpu_elig & ~gnt_disp;
    disp_word   = disp_pend ? disp_addr_q : disp_addr[AW-1:1];
    tag_in       = TAG_IDLE;
    tag_in.valid = gnt_disp | gnt_cpu;
    tag_in.owner = gnt_cpu ? OWN_CPU : OWN_DISP;
    tag_in.wr    = gnt_cpu & cpu_we;
    ret_disp    = tag_out.valid & (tag_out.owner == OWN_DISP);
    ret_cpu     = tag_out.valid & (tag_out.owner == OWN_CPU);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_pend   <= 1'b0;
      disp_addr_q <= '0;
      disp_infl   <= 1'b0;
      cpu_infl    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      last_disp   <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 2'b00;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      disp_ack    <= 1'b0;
      disp_rdata  <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      if (gnt_disp)         disp_pend <= 1'b0;
      else if (disp_req_ok) disp_pend <= 1'b1;
      if (disp_req_ok) disp_addr_q <= disp_addr[AW-1:1];

      if (gnt_disp)      disp_infl <= 1'b1;
      else if (ret_disp) disp_infl <= 1'b0;
      if (gnt_cpu)       cpu_infl  <= 1'b1;
      else if (ret_cpu)  cpu_infl  <= 1'b0;

      if (gnt_disp)     last_disp <= 1'b1;
      else if (gnt_cpu) last_disp <= 1'b0;

      mem_en    <= gnt_disp | gnt_cpu;
      mem_we    <= (gnt_cpu && cpu_we) ? cpu_be : 2'b00;
      mem_addr  <= gnt_cpu ? cpu_addr[AW-1:1] : disp_word;
      mem_wdata <= gnt_cpu ? cpu_wdata : 16'h0000;

      disp_ack  <= ret_disp;
      cpu_ack   <= ret_cpu;
      cpu_ack_q <= cpu_ack;
      if (ret_disp) disp_rdata <= mem_rdata;
      if (ret_cpu && !tag_out.wr) cpu_rdata <= mem_rdata;
    end
  end

  blit_memarb_tagpipe #(.DEPTH(RDLAT + 1)) u_tagpipe (
    .clk     (clk),
    .rstn    (rstn),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // A second display request before the first is acked is a master bug; it is dropped.
  assert property (@(posedge clk) disable iff (!rstn) !(disp_req && (disp_pend || disp_infl)));

endmodule

// File: tb/tb_blit_memarb.sv
// Scoreboard bench for blit_memarb against a behavioural RAM with RDLAT read latency.
module tb_blit_memarb;
  parameter int RDLAT = 1;
  localparam int AW  = 18;
  localparam int LAT = 2 + RDLAT;

  logic          clk, rstn;
  logic          disp_req, disp_ack, cpu_req, cpu_we, cpu_ack, mem_en;
  logic [AW-1:0] disp_addr, cpu_addr;
  logic [15:0]   disp_rdata, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [1:0]    cpu_be, mem_we;
  logic [AW-2:0] mem_addr;

  int checks = 0;
  int failures = 0;
  logic [15:0] disp_q[$];
  logic [15:0] cpu_q[$];
  logic [15:0] ram[int];
  logic [15:0] shadow[int];
  logic [15:0] rd_pipe[RDLAT];

  blit_memarb #(.RDLAT(RDLAT), .AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(int a);
    logic [31:0] v;
    v = a;
    return {v[7:0] ^ 8'h96, v[15:8] ^ v[7:0] ^ {7'b0, v[16]}};
  endfunction

  function automatic logic [15:0] ram_rd(int a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction

  function automatic logic [15:0] exp_rd(int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  // Behavioural pipelined RAM
  always @(posedge clk) begin
    logic [15:0] cur;
    int a;
    if (mem_en === 1'b1) begin
      a = int'(mem_addr);
      cur = ram_rd(a);
      rd_pipe[0] <= cur;
      if (mem_we[1]) cur[15:8] = mem_wdata[15:8];
      if (mem_we[0]) cur[7:0]  = mem_wdata[7:0];
      if (mem_we != 2'b00) ram[a] = cur;
    end
    for (int i = 1; i < RDLAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RDLAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; disp_req = 0; disp_addr = '0; cpu_req = 0; cpu_we = 0; cpu_be = 0;
    cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < RDLAT; i++) rd_pipe[i] = 16'h0;
    tick(); tick();
    checks++;
    if ({disp_ack, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata, disp_rdata, cpu_rdata} !== '0)
      begin failures++; $display("FAIL reset_outputs: got %h,%h,%h,%h,%h,%h,%h,%h want all 0",
        disp_ack, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata, disp_rdata, cpu_rdata); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic disp_single(string nm, logic [AW-1:0] addr, logic [AW-2:0] exp_word);
    int lat;
    logic [15:0] exp;
    disp_addr = addr; disp_req = 1'b1;
    disp_q.push_back(exp_rd(int'(exp_word)));
    tick(); disp_req = 1'b0;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== exp_word || mem_we !== 2'b00) begin
      failures++; $display("FAIL %s_issue: en=%b addr=%h we=%b want en=1 addr=%h we=00",
        nm, mem_en, mem_addr, mem_we, exp_word); end
    lat = 1;
    while (disp_ack !== 1'b1 && lat < LAT + 10) begin tick(); lat++; end
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, LAT); end
    exp = (disp_q.size() > 0) ? disp_q.pop_front() : 16'hxxxx;
    checks++;
    if (disp_rdata !== exp) begin
      failures++; $display("FAIL %s_rdata: got %h want %h", nm, disp_rdata, exp); end
    tick();
    checks++;
    if (disp_ack !== 1'b0) begin failures++; $display("FAIL %s_ack_pulse: got %b want 0", nm, disp_ack); end
  endtask

  task automatic test_disp_basic();
    disp_single("t1", 18'h00100, 17'h00080);
    disp_single("alias", 18'h3FFFF, 17'h1FFFF);
  endtask

  task automatic cpu_access(string nm, logic we, logic [1:0] be, logic [AW-1:0] addr,
                            logic [15:0] wd, output logic [15:0] rd, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    lat = 0;
    do begin tick(); lat++; end while (cpu_ack !== 1'b1 && lat < LAT + 10);
    rd = cpu_rdata;
    tick(); cpu_req = 1'b0; cpu_we = 1'b0;
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, LAT); end
  endtask

  task automatic test_cpu_write();
    logic [15:0] old, rd, want, lo;
    int lat;
    old = cpu_rdata;
    lo = init_word(32'h101);
    shadow[32'h101] = {8'hAB, lo[7:0]};
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b10; cpu_addr = 18'h00202; cpu_wdata = 16'hABCD;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 2'b10 || mem_addr !== 17'h0101 || mem_wdata !== 16'hABCD) begin
      failures++; $display("FAIL t2_issue: en=%b we=%b addr=%h wd=%h want 1,10,0101,abcd",
        mem_en, mem_we, mem_addr, mem_wdata); end
    lat = 1;
    while (cpu_ack !== 1'b1 && lat < LAT + 10) begin tick(); lat++; end
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL t2_wr_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (cpu_rdata !== old) begin
      failures++; $display("FAIL t2_wr_rdata_hold: got %h want %h", cpu_rdata, old); end
    tick(); cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    cpu_access("t2_rd", 1'b0, 2'b11, 18'h00202, 16'h0, rd, lat);
    want = {8'hAB, lo[7:0]};
    checks++;
    if (rd !== want) begin failures++; $display("FAIL t2_readback: got %h want %h", rd, want); end
    tick();
  endtask

  task automatic test_contention();
    int d_cyc, c_cyc;
    logic both;
    logic [15:0] d_dat, c_dat, d_exp, c_exp;
    d_cyc = 0; c_cyc = 0; both = 0; d_dat = 'x; c_dat = 'x;
    d_exp = exp_rd(32'h180); c_exp = exp_rd(32'h201);
    disp_req = 1'b1; disp_addr = 18'h00300;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 18'h00402;
    for (int c = 1; c <= LAT + 4; c++) begin
      tick();
      disp_req = 1'b0;
      if (c_cyc > 0) cpu_req = 1'b0;
      if (c == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 17'h0180 || mem_we !== 2'b00) begin
          failures++; $display("FAIL t3_first_disp: en=%b addr=%h want 1,0180", mem_en, mem_addr); end
      end
      if (c == 2) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 17'h0201) begin
          failures++; $display("FAIL t3_second_cpu: en=%b addr=%h want 1,0201", mem_en, mem_addr); end
      end
      if (disp_ack === 1'b1 && cpu_ack === 1'b1) both = 1'b1;
      if (disp_ack === 1'b1) begin d_cyc = c; d_dat = disp_rdata; end
      if (cpu_ack === 1'b1)  begin c_cyc = c; c_dat = cpu_rdata; end
    end
    cpu_req = 1'b0;
    checks++;
    if (d_cyc !== LAT) begin failures++; $display("FAIL t3_disp_ack_cycle: got %0d want %0d", d_cyc, LAT); end
    checks++;
    if (c_cyc !== LAT + 1) begin failures++; $display("FAIL t3_cpu_ack_cycle: got %0d want %0d", c_cyc, LAT + 1); end
    checks++;
    if (both !== 1'b0) begin failures++; $display("FAIL t3_ack_overlap: got %b want 0", both); end
    checks++;
    if (d_dat !== d_exp) begin failures++; $display("FAIL t3_disp_rdata: got %h want %h", d_dat, d_exp); end
    checks++;
    if (c_dat !== c_exp) begin failures++; $display("FAIL t3_cpu_rdata: got %h want %h", c_dat, c_exp); end
    tick(); tick();
  endtask

  task automatic test_alternate();
    int disp_done, cpu_done, delayed;
    logic stop;
    disp_done = 0; cpu_done = 0; delayed = 0; stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          logic [16:0] w;
          logic [15:0] exp;
          int lat;
          w = 17'($urandom);
          disp_addr = {w, 1'($urandom)}; disp_req = 1'b1;
          disp_q.push_back(exp_rd(int'(w)));
          lat = 0;
          do begin tick(); disp_req = 1'b0; lat++; end while (disp_ack !== 1'b1 && lat < LAT + 10);
          if (lat == LAT + 1) delayed++;
          checks++;
          if (lat !== LAT && lat !== LAT + 1) begin
            failures++; $display("FAIL t4_disp_latency[%0d]: got %0d want %0d..%0d", i, lat, LAT, LAT + 1); end
          exp = (disp_q.size() > 0) ? disp_q.pop_front() : 16'hxxxx;
          checks++;
          if (disp_ack !== 1'b1 || disp_rdata !== exp) begin
            failures++; $display("FAIL t4_disp_rdata[%0d]: ack=%b got %h want %h", i, disp_ack, disp_rdata, exp); end
          else disp_done++;
          tick();
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          logic [16:0] w;
          logic [15:0] exp;
          int lat;
          w = 17'($urandom);
          cpu_addr = {w, 1'b0}; cpu_we = 1'b0; cpu_be = 2'b11; cpu_req = 1'b1;
          cpu_q.push_back(exp_rd(int'(w)));
          lat = 0;
          do begin tick(); lat++; end while (cpu_ack !== 1'b1 && lat < LAT + 10);
          checks++;
          if (lat !== LAT && lat !== LAT + 1) begin
            failures++; $display("FAIL t4_cpu_latency: got %0d want %0d..%0d", lat, LAT, LAT + 1); end
          exp = (cpu_q.size() > 0) ? cpu_q.pop_front() : 16'hxxxx;
          checks++;
          if (cpu_rdata !== exp) begin
            failures++; $display("FAIL t4_cpu_rdata: addr=%h got %h want %h", w, cpu_rdata, exp); end
          cpu_done++;
          tick(); cpu_req = 1'b0;
          tick();
        end
      end
    join
    checks++;
    if (disp_done !== 50) begin failures++; $display("FAIL t4_disp_count: got %0d want 50", disp_done); end
    checks++;
    if (cpu_done < 20) begin failures++; $display("FAIL t4_cpu_count: got %0d want >=20", cpu_done); end
    checks++;
    if (delayed < 1) begin failures++; $display("FAIL t4_contention_seen: got %0d want >=1", delayed); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int acks;
    disp_req = 1'b1; disp_addr = 18'h00500;
    tick(); disp_req = 1'b0;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 17'h0280) begin
      failures++; $display("FAIL t5_issue: en=%b addr=%h want 1,0280", mem_en, mem_addr); end
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({disp_ack, cpu_ack, mem_en} !== 3'b000) begin
      failures++; $display("FAIL t5_reset_clear: got %b want 000", {disp_ack, cpu_ack, mem_en}); end
    tick();
    rstn = 1'b1;
    acks = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (disp_ack !== 1'b0) acks++; end
    checks++;
    if (acks !== 0) begin failures++; $display("FAIL t5_stale_ack: got %0d acks want 0", acks); end
    disp_single("t5_fresh", 18'h00600, 17'h00300);
  endtask

  initial begin
    test_reset();
    test_disp_basic();
    test_cpu_write();
    test_contention();
    test_alternate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
